soc_system_default_16b_reader: RTL and testbench

Avalon-MM read master that sits directly downstream of the 4-word × 32-bit default-value on-chip RAM. On a start pulse it fetches every word of the RAM in address order and streams each word as two 16-bit halfwords (low half first) on an Avalon-ST source with valid/ready backpressure. It is the consumer that turns the RAM's default table into a framed 16-bit packet for the downstream datapath.

---
 rtl/soc_system_default_16b_reader.sv | 165 ++++++++++++++++
 tb/tb_soc_system_default_16b_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_default_16b_reader.sv
// soc_system_default_16b_reader
// Avalon-MM read master for the 4x32 default-value RAM. On a start pulse it
// reads every RAM word in address order. It sends each word as two 16-bit
// Avalon-ST beats, low half first, with valid/ready backpressure.
// Optional feature: define DEFAULT_16B_READER_CHECKSUM_EN to append one
// extra beat holding the mod-2^16 sum of all halfwords. When the checksum
// is enabled, endofpacket moves to that extra beat.
module soc_system_default_16b_reader #(
  parameter int WORDS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [15:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_startofpacket,
  output logic              src_endofpacket
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_EMIT_LO,
    S_EMIT_HI,
`ifdef DEFAULT_16B_READER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         word_q;
  logic                clken_q;
  logic                last_word;

`ifdef DEFAULT_16B_READER_CHECKSUM_EN
  logic [15:0]         csum_q;

  // Adds both halves of a word to the running sum; carries out of bit 15 are dropped.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [31:0] w);
    csum_add = acc + w[15:0] + w[31:16];
  endfunction
`endif

  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = clken_q;
  assign last_word      = (idx_q == ADDR_W'(WORDS - 1));

  // Control state: the FSM, the word index, and the RAM clock enable.
  // The clock enable is held low during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clken_q <= 1'b1;
    end
  end

  // Data path: the word register loads in CAPTURE, when the RAM read data is valid.
  // These registers need no reset, because every output is gated by the state.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE) begin
      word_q <= mem_readdata;
    end
`ifdef DEFAULT_16B_READER_CHECKSUM_EN
    if (state_q == S_IDLE && start) begin
      csum_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      csum_q <= csum_add(csum_q, mem_readdata);
    end
`endif
  end

  // Next-state logic, plus Moore-style bus and stream outputs decoded from the current state.
  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    busy              = (state_q != S_IDLE);
    done              = 1'b0;
    mem_address       = '0;
    mem_chipselect    = 1'b0;
    src_data          = '0;
    src_valid         = 1'b0;
    src_startofpacket = 1'b0;
    src_endofpacket   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_chipselect = 1'b1;
        mem_address    = idx_q;
        state_d        = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_EMIT_LO;
      end
      S_EMIT_LO: begin
        src_valid         = 1'b1;
        src_data          = word_q[15:0];
        src_startofpacket = (idx_q == '0);
        if (src_ready) begin
          state_d = S_EMIT_HI;
        end
      end
      S_EMIT_HI: begin
        src_valid = 1'b1;
        src_data  = word_q[31:16];
`ifndef DEFAULT_16B_READER_CHECKSUM_EN
        src_endofpacket = last_word;
`endif
        if (src_ready) begin
          if (!last_word) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
`ifdef DEFAULT_16B_READER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef DEFAULT_16B_READER_CHECKSUM_EN
      S_CSUM: begin
        src_valid       = 1'b1;
        src_data        = csum_q;
        src_endofpacket = 1'b1;
        if (src_ready) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_soc_system_default_16b_reader.sv
// Directed testbench for soc_system_default_16b_reader.
// Expectations depend on DEFAULT_16B_READER_CHECKSUM_EN.
module tb_soc_system_default_16b_reader;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 2;
`ifdef DEFAULT_16B_READER_CHECKSUM_EN
  localparam int NB       = 2 * WORDS + 1;
  localparam int DONE_CYC = 18;
`else
  localparam int NB       = 2 * WORDS;
  localparam int DONE_CYC = 17;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata = '0;
  logic [15:0]       src_data;
  logic              src_valid, src_ready, src_startofpacket, src_endofpacket;

  logic [31:0] ram [WORDS];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int n_cs     = 0;
  logic [15:0] q_data [$];
  logic        q_sop  [$];
  logic        q_eop  [$];
  int          q_cyc  [$];

  soc_system_default_16b_reader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .mem_address       (mem_address),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_byteenable    (mem_byteenable),
    .mem_clken         (mem_clken),
    .mem_readdata      (mem_readdata),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_startofpacket (src_startofpacket),
    .src_endofpacket   (src_endofpacket)
  );

  always #5 clk = ~clk;

  // The RAM has a registered read port, so data appears one cycle after the select.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) mem_readdata <= ram[mem_address];
    cyc <= cyc + 1;
  end

  // The stream monitor samples mid-cycle and logs each beat that is accepted.
  always @(negedge clk) begin
    if (src_valid && src_ready) begin
      q_data.push_back(src_data);
      q_sop.push_back(src_startofpacket);
      q_eop.push_back(src_endofpacket);
      q_cyc.push_back(cyc - t0);
    end
    if (mem_chipselect) n_cs <= n_cs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_cs"}, mem_chipselect, 0);
    check({tag, "_clken"}, mem_clken, 0);
    check({tag, "_valid"}, src_valid, 0);
    check({tag, "_data"}, src_data, 0);
    check({tag, "_sop"}, src_startofpacket, 0);
    check({tag, "_eop"}, src_endofpacket, 0);
  endtask

  // Runs ncyc cycles. The task pulses start at cycle 0, and again at restart_at.
  // It holds src_ready low for stall_len cycles starting at stall_from.
  task automatic run(input int ncyc, input int stall_from, input int stall_len, input int restart_at);
    int dc;
    dc = DONE_CYC + stall_len;
    t0 = cyc;
    for (int k = 0; k < ncyc; k++) begin
      start     = (k == 0) || (k == restart_at);
      src_ready = !(stall_len > 0 && k >= stall_from && k < stall_from + stall_len);
      if (!src_ready) begin
        check("stall_valid", src_valid, 1);
        check("stall_data", src_data, 32'h4444);
        check("stall_no_fetch", mem_chipselect, 0);
      end
      check("busy", busy, (k >= 1 && k <= dc));
      check("done", done, (k == dc));
      tick();
    end
    start     = 1'b0;
    src_ready = 1'b1;
  endtask

  task automatic check_beats(input int base, input int cs0, input int stall_len, input logic [15:0] exp_csum);
    logic [15:0] ed;
    int          ec;
    check("beat_count", q_data.size() - base, NB);
    check("fetch_count", n_cs - cs0, WORDS);
    for (int i = 0; i < NB; i++) begin
      if (base + i < q_data.size()) begin
        if (i < 2 * WORDS) begin
          ed = (i % 2 == 1) ? ram[i / 2][31:16] : ram[i / 2][15:0];
          ec = 3 + 4 * (i / 2) + (i % 2);
        end else begin
          ed = exp_csum;
          ec = 4 * WORDS + 1;
        end
        if (i >= 2) ec = ec + stall_len;
        check("beat_data", q_data[base + i], ed);
        check("beat_cycle", q_cyc[base + i], ec);
        check("beat_sop", q_sop[base + i], (i == 0));
        check("beat_eop", q_eop[base + i], (i == NB - 1));
      end
    end
  endtask

  initial begin
    int base, cs0;
    reset_n   = 1'b0;
    start     = 1'b0;
    src_ready = 1'b1;
    ram[0] = 32'h11112222;
    ram[1] = 32'h33334444;
    ram[2] = 32'h55556666;
    ram[3] = 32'h77778888;
    repeat (3) tick();
    check_reset_outs("rst");
    check("mem_write", mem_write, 0);
    check("mem_be", mem_byteenable, 4'hF);
    reset_n = 1'b1;
    tick();
    check("clken_after_rst", mem_clken, 1);

    // Basic packet with no backpressure
    base = q_data.size(); cs0 = n_cs;
    run(DONE_CYC + 1, 0, 0, -1);
    check_beats(base, cs0, 0, 16'h6664);

    // Five-cycle stall on beat 0x4444
    base = q_data.size(); cs0 = n_cs;
    run(DONE_CYC + 6, 7, 5, -1);
    check_beats(base, cs0, 5, 16'h6664);

    // A start pulse during busy is ignored; the next start right after done is accepted
    base = q_data.size(); cs0 = n_cs;
    run(DONE_CYC + 1, 0, 0, 6);
    check_beats(base, cs0, 0, 16'h6664);
    base = q_data.size(); cs0 = n_cs;
    run(DONE_CYC + 1, 0, 0, -1);
    check_beats(base, cs0, 0, 16'h6664);

    // Reset in the middle of a packet
    base = q_data.size();
    run(9, 0, 0, -1);
    reset_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    tick();
    tick();
    check_reset_outs("midrst_hold");
    check("midrst_beats", q_data.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < q_data.size()) check("midrst_no_eop", q_eop[base + i], 0);
    end
    reset_n = 1'b1;
    tick();
    base = q_data.size(); cs0 = n_cs;
    run(DONE_CYC + 1, 0, 0, -1);
    check_beats(base, cs0, 0, 16'h6664);

    // Checksum carry is discarded
    ram[0] = 32'hFFFFFFFF;
    ram[1] = 32'h00000000;
    ram[2] = 32'h00000000;
    ram[3] = 32'h00000000;
    base = q_data.size(); cs0 = n_cs;
    run(DONE_CYC + 1, 0, 0, -1);
    check_beats(base, cs0, 0, 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
